// File: rtl/mtc_rx_decoder.sv
// Receive side of the MTC->SL interface: per-link FIFOs merged round-robin into one
// valid/ready stream, with per-procflag saturating counters and a drop counter.
module mtc_rx_decoder #(
    parameter int unsigned N_LINKS                  = 3,
    parameter int unsigned FIFO_DEPTH               = 8,
    parameter int unsigned CNT_WIDTH                = 16,
    parameter int unsigned MTC2SL_LEN               = 24,
    parameter int unsigned MTC2SL_MDT_PROCFLAGS_LSB = 8,
    parameter int unsigned MTC2SL_MDT_PROCFLAGS_MSB = 11,
    localparam int unsigned LW = (N_LINKS > 1) ? $clog2(N_LINKS) : 1
) (
    input  logic                                   clock,
    input  logic                                   rst,
    input  logic [N_LINKS-1:0][MTC2SL_LEN-1:0]     mtc_in,
    output logic [MTC2SL_LEN-2:0]                  out_data,
    output logic [LW-1:0]                          out_link,
    output logic [3:0]                             out_procflags,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    input  logic [3:0]                             cnt_sel,
    output logic [CNT_WIDTH-1:0]                   cnt_value,
    output logic [CNT_WIDTH-1:0]                   drop_count,
    output logic                                   overflow,
    input  logic                                   cnt_clr
);
    localparam int unsigned PW = MTC2SL_LEN - 1;
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned DW = $clog2(N_LINKS + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [PW-1:0]        mem_q [N_LINKS][FIFO_DEPTH];
    logic [PW-1:0]        mem_d [N_LINKS][FIFO_DEPTH];
    logic [AW-1:0]        wr_q [N_LINKS], wr_d [N_LINKS];
    logic [AW-1:0]        rd_q [N_LINKS], rd_d [N_LINKS];
    logic [AW:0]          occ_q [N_LINKS], occ_d [N_LINKS];
    logic [LW-1:0]        rr_q, rr_d;
    logic                 valid_q, valid_d;
    logic [PW-1:0]        data_q, data_d;
    logic [LW-1:0]        link_q, link_d;
    logic [3:0]           pf_q, pf_d;
    logic [CNT_WIDTH-1:0] ctr_q [16], ctr_d [16];
    logic [CNT_WIDTH-1:0] cnt_value_q, cnt_value_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;
    logic                 ovf_q, ovf_d;

    logic                 hs, ld, found;
    logic [LW-1:0]        gnt;
    logic                 push [N_LINKS];
    logic                 pop [N_LINKS];
    logic [DW-1:0]        ndrop;
    logic [CNT_WIDTH:0]   drop_sum;

    // Round-robin arbiter over registered occupancy, starting at rr_q
    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        gnt   = '0;
        for (int unsigned k = 0; k < N_LINKS; k++) begin
            idx = (32'(rr_q) + k) % N_LINKS;
            if (!found && occ_q[idx] != '0) begin
                found = 1'b1;
                gnt   = LW'(idx);
            end
        end
    end

    // FIFO capture, output stage load and statistics
    always_comb begin
        mem_d       = mem_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        occ_d       = occ_q;
        rr_d        = rr_q;
        valid_d     = valid_q;
        data_d      = data_q;
        link_d      = link_q;
        pf_d        = pf_q;
        ctr_d       = ctr_q;
        drop_d      = drop_q;
        ovf_d       = ovf_q;
        cnt_value_d = ctr_q[cnt_sel];
        hs          = valid_q & out_ready;
        ld          = ~valid_q | out_ready;
        ndrop       = '0;

        for (int i = 0; i < N_LINKS; i++) begin
            push[i] = 1'b0;
            pop[i]  = ld && found && (gnt == LW'(i));
            if (mtc_in[i][MTC2SL_LEN-1]) begin
                // A same-cycle pop never makes room for a push
                if (occ_q[i] == (AW+1)'(FIFO_DEPTH)) ndrop = ndrop + DW'(1);
                else                                   push[i] = 1'b1;
            end
            if (push[i]) begin
                mem_d[i][wr_q[i]] = mtc_in[i][PW-1:0];
                wr_d[i]           = wr_q[i] + 1'b1;
            end
            if (pop[i]) rd_d[i] = rd_q[i] + 1'b1;
            if (push[i] && !pop[i])      occ_d[i] = occ_q[i] + 1'b1;
            else if (pop[i] && !push[i]) occ_d[i] = occ_q[i] - 1'b1;
        end

        if (ld) begin
            valid_d = found;
            if (found) begin
                data_d = mem_q[gnt][rd_q[gnt]];
                link_d = gnt;
                pf_d   = mem_q[gnt][rd_q[gnt]][MTC2SL_MDT_PROCFLAGS_MSB:MTC2SL_MDT_PROCFLAGS_LSB];
                rr_d   = (gnt == LW'(N_LINKS - 1)) ? '0 : gnt + 1'b1;
            end
        end

        drop_sum = {1'b0, drop_q} + (CNT_WIDTH+1)'(ndrop);
        if (cnt_clr) begin
            for (int c = 0; c < 16; c++) ctr_d[c] = '0;
            drop_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if (hs && ctr_q[pf_q] != CNT_MAX) ctr_d[pf_q] = ctr_q[pf_q] + 1'b1;
            drop_d = drop_sum[CNT_WIDTH] ? CNT_MAX : drop_sum[CNT_WIDTH-1:0];
            if (ndrop != '0) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_q        <= '{default: '0};
            rd_q        <= '{default: '0};
            occ_q       <= '{default: '0};
            rr_q        <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            link_q      <= '0;
            pf_q        <= '0;
            ctr_q       <= '{default: '0};
            cnt_value_q <= '0;
            drop_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            occ_q       <= occ_d;
            rr_q        <= rr_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            link_q      <= link_d;
            pf_q        <= pf_d;
            ctr_q       <= ctr_d;
            cnt_value_q <= cnt_value_d;
            drop_q      <= drop_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_data      = data_q;
    assign out_link      = link_q;
    assign out_procflags = pf_q;
    assign cnt_value     = cnt_value_q;
    assign drop_count    = drop_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_mtc_rx_decoder.sv
// Bench for mtc_rx_decoder: directed scenarios plus random traffic, checked each cycle
// against a queue-based transaction model of the receive path.
module tb_mtc_rx_decoder;
    localparam int N     = 3;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int LEN   = 24;
    localparam int PW    = LEN - 1;
    localparam int MAXC  = (1 << CW) - 1;

    logic                      clock = 1'b0;
    logic                      rst = 1'b1;
    logic [N-1:0][LEN-1:0]     mtc_in = '0;
    logic [PW-1:0]             out_data;
    logic [1:0]                out_link;
    logic [3:0]                out_procflags;
    logic                      out_valid;
    logic                      out_ready = 1'b0;
    logic [3:0]                cnt_sel = '0;
    logic [CW-1:0]             cnt_value;
    logic [CW-1:0]             drop_count;
    logic                      overflow;
    logic                      cnt_clr = 1'b0;

    mtc_rx_decoder #(.N_LINKS(N), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW), .MTC2SL_LEN(LEN)) dut (
        .clock(clock), .rst(rst), .mtc_in(mtc_in), .out_data(out_data), .out_link(out_link),
        .out_procflags(out_procflags), .out_valid(out_valid), .out_ready(out_ready),
        .cnt_sel(cnt_sel), .cnt_value(cnt_value), .drop_count(drop_count),
        .overflow(overflow), .cnt_clr(cnt_clr));

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: one queue per link plus the presented packet
    logic [PW-1:0] mq [N][$];
    bit            m_valid = 0;
    logic [PW-1:0] m_data = '0;
    int            m_link = 0, m_pf = 0, m_rr = 0;
    int            m_ctr [16];
    int            m_drop = 0, m_cntval = 0;
    bit            m_ovf = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int  cv, gnt, nd, hs_pf, idx;
        bit  hs, ld;
        bit  full [N];
        if (rst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_valid = 0; m_data = '0; m_link = 0; m_pf = 0; m_rr = 0;
            for (int c = 0; c < 16; c++) m_ctr[c] = 0;
            m_drop = 0; m_ovf = 0; m_cntval = 0;
            return;
        end
        cv    = m_ctr[cnt_sel];
        hs    = m_valid && out_ready;
        ld    = !m_valid || out_ready;
        hs_pf = m_pf;
        gnt   = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (ld && gnt < 0 && mq[idx].size() > 0) gnt = idx;
        end
        for (int i = 0; i < N; i++) full[i] = (mq[i].size() >= DEPTH);
        if (ld) begin
            if (gnt >= 0) begin
                m_data  = mq[gnt].pop_front();
                m_link  = gnt;
                m_pf    = int'(m_data[11:8]);
                m_valid = 1;
                m_rr    = (gnt + 1) % N;
            end else m_valid = 0;
        end
        nd = 0;
        for (int i = 0; i < N; i++) begin
            if (mtc_in[i][LEN-1]) begin
                if (full[i]) nd++;
                else mq[i].push_back(mtc_in[i][PW-1:0]);
            end
        end
        if (cnt_clr) begin
            for (int c = 0; c < 16; c++) m_ctr[c] = 0;
            m_drop = 0; m_ovf = 0;
        end else begin
            if (hs && m_ctr[hs_pf] < MAXC) m_ctr[hs_pf]++;
            m_drop = (m_drop + nd > MAXC) ? MAXC : m_drop + nd;
            if (nd > 0) m_ovf = 1;
        end
        m_cntval = cv;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_link", 32'(out_link), 32'(m_link));
            chk("out_procflags", 32'(out_procflags), 32'(m_pf));
        end
        chk("cnt_value", 32'(cnt_value), 32'(m_cntval));
        chk("drop_count", 32'(drop_count), 32'(m_drop));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    function automatic logic [LEN-1:0] mk(input logic [3:0] pf, input logic [PW-1:0] r);
        logic [LEN-1:0] w;
        w = {1'b1, r};
        w[11:8] = pf;
        return w;
    endfunction

    task automatic do_reset();
        rst = 1'b1; mtc_in = '0; cnt_clr = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LEN-1:0] w;
        int             seq [$];
        int             exp_a [3];
        int             exp_b [3];
        logic [PW-1:0]  sent [$];
        logic [PW-1:0]  got [$];
        int             n;

        exp_a = '{0, 1, 2};
        exp_b = '{1, 2, 0};

        // Reset state
        do_reset();
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_link", 32'(out_link), 32'd0);
        chk("rst_pf", 32'(out_procflags), 32'd0);

        // 1: single packet latency and counter readback
        out_ready = 1'b1; cnt_sel = 4'd1;
        w = mk(4'd1, PW'($urandom));
        mtc_in[0] = w;
        step();
        mtc_in = '0;
        chk("t1_valid_early", 32'(out_valid), 32'd0);
        step();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_link", 32'(out_link), 32'd0);
        chk("t1_data", 32'(out_data), 32'(w[PW-1:0]));
        step();
        step();
        chk("t1_cnt", 32'(cnt_value), 32'd1);

        // 2: round-robin order from rr_ptr=0, then from rr_ptr=1
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) mtc_in[i] = mk(4'(i), PW'($urandom));
        step();
        mtc_in = '0;
        for (int s = 0; s < 5; s++) begin
            step();
            if (out_valid) seq.push_back(int'(out_link));
        end
        chk("t2_count_a", 32'(seq.size()), 32'd3);
        for (int s = 0; s < 3; s++) chk("t2_order_a", 32'(seq[s]), 32'(exp_a[s]));
        seq.delete();
        mtc_in[0] = mk(4'd0, PW'($urandom));
        step();
        mtc_in = '0;
        step(); step(); step();
        for (int i = 0; i < N; i++) mtc_in[i] = mk(4'(i), PW'($urandom));
        step();
        mtc_in = '0;
        for (int s = 0; s < 5; s++) begin
            step();
            if (out_valid) seq.push_back(int'(out_link));
        end
        chk("t2_count_b", 32'(seq.size()), 32'd3);
        for (int s = 0; s < 3; s++) chk("t2_order_b", 32'(seq[s]), 32'(exp_b[s]));

        // 3: backpressure fills FIFO plus output register, one drop
        do_reset();
        out_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
            w = mk(4'(s), PW'($urandom));
            if (s < 9) sent.push_back(w[PW-1:0]);
            mtc_in[0] = w;
            step();
        end
        mtc_in = '0;
        chk("t3_drop", 32'(drop_count), 32'd1);
        chk("t3_ovf", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        n = 0;
        for (int s = 0; s < 9; s++) begin
            if (out_valid) begin n++; got.push_back(out_data); end
            step();
        end
        chk("t3_drained", 32'(n), 32'd9);
        chk("t3_empty", 32'(out_valid), 32'd0);
        for (int s = 0; s < 9; s++) if (s < got.size()) chk("t3_order", 32'(got[s]), 32'(sent[s]));

        // 4: counter saturation at CNT_WIDTH=4
        do_reset();
        out_ready = 1'b1;
        for (int s = 0; s < 20; s++) begin
            mtc_in = '0;
            mtc_in[s % N] = mk(4'd6, PW'($urandom));
            step();
        end
        mtc_in = '0;
        for (int s = 0; s < 6; s++) step();
        cnt_sel = 4'd6;
        step();
        chk("t4_sat", 32'(cnt_value), 32'd15);
        for (int c = 0; c < 16; c++) begin
            cnt_sel = 4'(c);
            step();
            if (c != 6) chk("t4_other", 32'(cnt_value), 32'd0);
        end

        // 5: cnt_clr beats a same-edge handshake and drop
        do_reset();
        out_ready = 1'b0;
        for (int s = 0; s < 9; s++) begin
            mtc_in[1] = mk(4'd2, PW'($urandom));
            step();
        end
        out_ready = 1'b1; cnt_clr = 1'b1;
        mtc_in[1] = mk(4'd2, PW'($urandom));
        step();
        mtc_in = '0; cnt_clr = 1'b0; out_ready = 1'b0; cnt_sel = 4'd2;
        chk("t5_drop", 32'(drop_count), 32'd0);
        chk("t5_ovf", 32'(overflow), 32'd0);
        step();
        chk("t5_cnt2", 32'(cnt_value), 32'd0);

        // 6: reset mid-operation discards everything
        do_reset();
        out_ready = 1'b0;
        cnt_sel = 4'd3;
        for (int s = 0; s < 6; s++) begin
            mtc_in[2] = mk(4'd3, PW'($urandom));
            step();
        end
        mtc_in = '0;
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        n = 0;
        for (int s = 0; s < 12; s++) begin
            step();
            if (out_valid) n++;
        end
        chk("t6_no_emerge", 32'(n), 32'd0);
        chk("t6_cnt3", 32'(cnt_value), 32'd0);
        chk("t6_drop", 32'(drop_count), 32'd0);

        // Random traffic against the model
        for (int s = 0; s < 500; s++) begin
            for (int i = 0; i < N; i++)
                mtc_in[i] = ($urandom_range(0, 99) < 45) ? mk(4'($urandom), PW'($urandom))
                                                         : {1'b0, PW'($urandom)};
            out_ready = ($urandom_range(0, 99) < 60);
            cnt_sel   = 4'($urandom);
            cnt_clr   = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; cnt_clr = 1'b0; mtc_in = '0; out_ready = 1'b1;
        for (int s = 0; s < 30; s++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
